// File: rtl/fetch_unit.sv
// IF stage: PC, instruction-memory handshake, IF/ID register and branch/flush redirect.
// Optional flush counter output enabled by defining FETCH_FLUSH_CNT_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        IF_ID_sync_nop,
  input  logic [2:0]  IF_branch_select,
  input  logic [15:0] branch_target,
  input  logic [15:0] branch_return_addr,
  output logic [15:0] ID_instr,
  output logic [15:0] ID_pc_plus1,
  output logic        ID_valid,
  output logic [15:0] pc
`ifdef FETCH_FLUSH_CNT_EN
  ,
  output logic [15:0] flush_cnt
`endif
);

  localparam logic [1:0] S_RST   = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [15:0] drain_addr;
  logic [15:0] hold_buf;
  logic [15:0] target;
  logic [15:0] pc_plus1;
  logic        flush;

  // A stalled ID has not resolved its branch yet, so stall masks the flush.
  always_comb begin
    flush    = IF_ID_sync_nop & ~stall;
    pc_plus1 = pc + 16'd1;
    if (IF_branch_select[2] || IF_branch_select[1]) begin
      target = branch_target;
    end else if (IF_branch_select[0]) begin
      target = branch_return_addr;
    end else begin
      target = pc;
    end
    imem_req  = (state == S_FETCH) || (state == S_DRAIN);
    imem_addr = (state == S_DRAIN) ? drain_addr : pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RST;
      pc          <= RESET_PC;
      drain_addr  <= 16'h0000;
      hold_buf    <= 16'h0000;
      ID_instr    <= NOP_INSTR;
      ID_pc_plus1 <= 16'h0000;
      ID_valid    <= 1'b0;
    end else begin
      case (state)
        S_RST: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (flush) begin
            pc       <= target;
            ID_instr <= NOP_INSTR;
            ID_valid <= 1'b0;
            // The wrong-path request is still in flight; wait it out at its address.
            if (!imem_ready) begin
              drain_addr <= pc;
              state      <= S_DRAIN;
            end
          end else if (imem_ready && !stall) begin
            ID_instr    <= imem_rdata;
            ID_pc_plus1 <= pc_plus1;
            ID_valid    <= 1'b1;
            pc          <= pc_plus1;
          end else if (imem_ready && stall) begin
            hold_buf <= imem_rdata;
            state    <= S_HOLD;
          end else if (!stall) begin
            ID_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (flush) begin
            pc       <= target;
            ID_instr <= NOP_INSTR;
            ID_valid <= 1'b0;
            state    <= S_FETCH;
          end else if (!stall) begin
            ID_instr    <= hold_buf;
            ID_pc_plus1 <= pc_plus1;
            ID_valid    <= 1'b1;
            pc          <= pc_plus1;
            state       <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (flush) begin
            pc <= target;
          end
          if (imem_ready) begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_RST;
        end
      endcase
    end
  end

`ifdef FETCH_FLUSH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= 16'h0000;
    end else if (flush && (flush_cnt != 16'hFFFF)) begin
      flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the 16-bit pipeline and the consumer side of the ID-stage branch/flush interface.
- Holds the PC and drives the instruction-memory request/ready handshake.
- Owns the IF/ID pipeline register.
- Consumes the branch select, register return address and sync-NOP flush produced in ID. Redirects the PC, squashes the wrong-path fetch and inserts a NOP bubble into ID.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, encoding written into ID_instr on flush or reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  16  word address of the request.
- imem_ready  in  1  response valid, same cycle as imem_rdata.
- imem_rdata  in  16  fetched instruction.
- stall  in  1  hazard unit freeze of IF and IF/ID.
- IF_ID_sync_nop  in  1  flush request from ID.
- IF_branch_select  in  3  {bl, beq_true, br}.
- branch_target  in  16  PC-relative target for bl/beq, computed in ID.
- branch_return_addr  in  16  register target for br.
- ID_instr  out  16  IF/ID instruction.
- ID_pc_plus1  out  16  IF/ID PC+1; used as the link value.
- ID_valid  out  1  IF/ID holds a real instruction.
- pc  out  16  current PC.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=RST, imem_req=0.
  - ID_instr=NOP_INSTR, ID_pc_plus1=0, ID_valid=0.
  - Reset mid-transaction abandons any outstanding request.
- Word addressing: PC+1 is 16-bit modulo; 16'hFFFF wraps to 16'h0000.
- Redirect target, fixed priority bl > beq_true > br:
  - bl or beq_true: branch_target.
  - br: branch_return_addr.
  - select==0 with sync_nop=1: pc unchanged, bubble only.
- Effective flush: flush = IF_ID_sync_nop & ~stall. Stall wins, because ID is frozen and its branch is not yet resolved.
- imem_addr = (state==DRAIN) ? drain_addr : pc.
- States:
  - RST:
    - imem_req=0.
    - Always goes to FETCH on the next cycle.
  - FETCH:
    - imem_req=1; address held stable until imem_ready.
    - flush:
      - pc<=target; ID_instr<=NOP_INSTR, ID_valid<=0; response data discarded.
      - If imem_ready=1 this cycle, stay in FETCH.
      - Else drain_addr<=old pc, go to DRAIN.
    - imem_ready & ~stall:
      - ID_instr<=imem_rdata, ID_pc_plus1<=pc+1, ID_valid<=1, pc<=pc+1.
      - Back-to-back single-cycle fetches are allowed.
    - imem_ready & stall: buf<=imem_rdata; go to HOLD; IF/ID unchanged.
    - ~imem_ready & ~stall: ID_valid<=0 (bubble).
    - ~imem_ready & stall: IF/ID unchanged.
  - HOLD:
    - imem_req=0.
    - flush: discard buf, pc<=target, IF/ID<=NOP bubble, go to FETCH.
    - ~stall: ID_instr<=buf, ID_pc_plus1<=pc+1, ID_valid<=1, pc<=pc+1, go to FETCH.
    - stall: remain in HOLD.
  - DRAIN:
    - imem_req=1 at drain_addr.
    - On imem_ready: data dropped, go to FETCH at the redirected pc.
    - A further flush in DRAIN only updates pc. ID_valid stays 0 until the first FETCH completes.
- Latency:
  - Flush to first target instruction in ID: 1 cycle plus memory latency.
  - With zero-wait memory, exactly one bubble per taken branch.

Optional Feature:
- Macro: FETCH_FLUSH_CNT_EN.
- When defined:
  - Adds output flush_cnt, 16 bits.
  - Counts cycles with an effective flush; saturates at 16'hFFFF; reset to 0.
  - Increments in every state, including DRAIN.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ready tied 1, rdata=addr+16'h100:
  - ID_instr = 0100, 0101, 0102 on consecutive cycles; ID_valid=1 from cycle 2; pc increments by 1 per cycle.
- bl taken, select=3'b100, branch_target=16'h0040, br_return=16'h0099, sync_nop=1 at pc=5:
  - Next cycle ID_instr=NOP, ID_valid=0, pc=16'h0040.
  - Following cycle ID_instr=0140.
- beq and br asserted together (3'b011), target=16'h0010, return=16'h0020: pc becomes 16'h0010.
- imem_ready low for 3 cycles; sync_nop with br target 16'h0020 on cycle 1:
  - DRAIN keeps imem_addr at the old pc until ready; the stale rdata never appears in ID.
  - Next request addr=16'h0020.
- stall=1 while imem_ready=1:
  - Data buffered and IF/ID unchanged; sync_nop asserted during stall is ignored.
  - On stall release, the buffered instruction enters ID with correct ID_pc_plus1.
- pc=16'hFFFF fetch → pc=16'h0000.
- rst_n pulsed low mid-DRAIN → outputs return to reset values immediately.
- With FETCH_FLUSH_CNT_EN: 3 flushes → flush_cnt=3.
